// File: rtl/easy6502_io.sv
// ---------------------------------------------------------------------------
// easy6502_io
//
// Memory-mapped I/O stage between the 65C02 data bus and the 2 KiB system
// RAM. Two easy6502 special addresses are decoded:
//   $00FE  random byte (low byte of a free-running 16-bit Galois LFSR)
//   $00FF  last key code (written by the CPU or by a debounced button press)
// Reads of these addresses are merged into the CPU read path, and CPU writes
// to them are kept away from RAM. Four push-buttons are synchronised and
// debounced. Each press loads the matching w/a/s/d ASCII code into $FF.
//
// Ports
//   clk           in   1   system clock (25 MHz)
//   reset         in   1   asynchronous reset, active-high
//   cpu_ce        in   1   one-clk strobe that ends each CPU cycle
//   cpu_address   in   16  CPU address bus
//   cpu_we        in   1   CPU write enable
//   cpu_wdata     in   8   CPU data out
//   cpu_rdata     out  8   data to CPU DI (1 clk after address, like RAM)
//   ram_write_en  out  1   RAM write enable, suppressed for $FE/$FF
//   ram_rdata     in   8   RAM dout (1 clk latency from address)
//   btn           in   4   raw buttons {right,left,down,up}, active-high
//   key_valid     out  1   high while $FF holds a nonzero value
// ---------------------------------------------------------------------------
module easy6502_io #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [7:0]  KEY_UP          = 8'h77,
    parameter logic [7:0]  KEY_DOWN        = 8'h73,
    parameter logic [7:0]  KEY_LEFT        = 8'h61,
    parameter logic [7:0]  KEY_RIGHT       = 8'h64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_address,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        ram_write_en,
    input  logic [7:0]  ram_rdata,
    input  logic [3:0]  btn,
    output logic        key_valid
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice;
    // keep at least one bit so a degenerate parameter still elaborates.
    localparam int unsigned    CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEL_RAM = 2'd0,
        SEL_FE  = 2'd1,
        SEL_FF  = 2'd2
    } sel_e;

    // One step of a right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [15:0]             lfsr_q, lfsr_d;
    sel_e                    sel_q, sel_d;
    logic [7:0]              rnd_q, rnd_d;
    logic [7:0]              key_q, key_d;
    logic [3:0]              sync1_q, sync2_q;
    logic [3:0]              deb_q, deb_d;
    logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic                    hit_fe, hit_ff, io_hit;
    logic [3:0]              press;

    // -----------------------------------------------------------------------
    // Address decode: exact 16-bit matches only, so RAM mirrors of $FE/$FF
    // (e.g. $08FE) stay ordinary RAM.
    // -----------------------------------------------------------------------
    always_comb begin
        hit_fe = (cpu_address == 16'h00FE);
        hit_ff = (cpu_address == 16'h00FF);
        io_hit = hit_fe | hit_ff;
    end

    assign ram_write_en = cpu_we & ~io_hit;
    assign key_valid    = |key_q;

    // -----------------------------------------------------------------------
    // Read path. The select and random byte are registered so an I/O read
    // returns after the same single clk as a RAM read.
    // -----------------------------------------------------------------------
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
        rnd_d  = lfsr_q[7:0];
        sel_d  = SEL_RAM;
        if (hit_fe) begin
            sel_d = SEL_FE;
        end else if (hit_ff) begin
            sel_d = SEL_FF;
        end
    end

    always_comb begin
        cpu_rdata = ram_rdata;
        case (sel_q)
            SEL_FE:  cpu_rdata = rnd_q;
            SEL_FF:  cpu_rdata = key_q;
            default: cpu_rdata = ram_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Debounce. While the synchronised level disagrees with the accepted
    // level the counter runs; any agreement (a glitch ending early) clears
    // it. On reaching the terminal count the new level is accepted. A rise
    // of the accepted level is the single-clk press event.
    // -----------------------------------------------------------------------
    always_comb begin
        deb_d = deb_q;
        press = 4'b0000;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Key register. The press is applied last so it overrides a CPU write
    // in the same clk; among presses up > down > left > right.
    // -----------------------------------------------------------------------
    always_comb begin
        key_d = key_q;
        if (cpu_ce && cpu_we && hit_ff) begin
            key_d = cpu_wdata;
        end
        if (press[0]) begin
            key_d = KEY_UP;
        end else if (press[1]) begin
            key_d = KEY_DOWN;
        end else if (press[2]) begin
            key_d = KEY_LEFT;
        end else if (press[3]) begin
            key_d = KEY_RIGHT;
        end
    end

    // -----------------------------------------------------------------------
    // Registers. The synchroniser is cleared on reset too, so a button held
    // through reset is re-debounced from scratch after release.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= SEED_EFF;
            sel_q   <= SEL_RAM;
            rnd_q   <= 8'h00;
            key_q   <= 8'h00;
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            deb_q   <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_easy6502_io.sv
module tb_easy6502_io;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic [15:0] cpu_address;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        ram_write_en;
    logic [7:0]  ram_rdata;
    logic [3:0]  btn;
    logic        key_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:2047];

    easy6502_io #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_ce       (cpu_ce),
        .cpu_address  (cpu_address),
        .cpu_we       (cpu_we),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .ram_write_en (ram_write_en),
        .ram_rdata    (ram_rdata),
        .btn          (btn),
        .key_valid    (key_valid)
    );

    always #5 clk = ~clk;

    // 2 KiB synchronous RAM, 1 clk read latency, aliased every $0800.
    always @(posedge clk) begin
        if (ram_write_en) mem[cpu_address[10:0]] <= cpu_wdata;
        ram_rdata <= mem[cpu_address[10:0]];
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output logic we_seen);
        cpu_address = a;
        cpu_wdata   = d;
        cpu_we      = 1'b1;
        cpu_ce      = 1'b1;
        #1 we_seen  = ram_write_en;
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_ce = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_address = a;
        cpu_ce      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_ce = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic wait_key(output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        cpu_ce      = 1'b0;
        cpu_we      = 1'b0;
        cpu_wdata   = 8'h00;
        cpu_address = 16'h00FE;
        btn         = 4'b0000;
        @(negedge clk);
        step(3);
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL reset_key_valid: got %b want 0", key_valid);
        end
        total++;
        if (ram_write_en !== 1'b0) begin
            bad++; $display("FAIL reset_ram_we: got %b want 0", ram_write_en);
        end
        total++;
        if (cpu_rdata !== ram_rdata) begin
            bad++; $display("FAIL reset_rdata_is_ram: got %h want %h", cpu_rdata, ram_rdata);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_v [4];
        logic [7:0] prev;
        int idx;
        exp_v[0] = 8'hE1; exp_v[1] = 8'h9C; exp_v[2] = 8'h13; exp_v[3] = 8'h62;
        reset = 1'b1;
        step(2);
        cpu_address = 16'h00FE;
        reset = 1'b0;
        idx  = 0;
        prev = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            cpu_ce = ((k - 1) % 3 == 0);
            step(1);
            if ((k - 1) % 3 == 0) begin
                total++;
                if (cpu_rdata !== exp_v[idx]) begin
                    bad++; $display("FAIL rnd_read%0d: got %h want %h", idx, cpu_rdata, exp_v[idx]);
                end
                if (idx > 0) begin
                    total++;
                    if (cpu_rdata === prev) begin
                        bad++; $display("FAIL rnd_changes%0d: got %h want value differing from %h", idx, cpu_rdata, prev);
                    end
                end
                prev = cpu_rdata;
                idx++;
            end
        end
        cpu_ce = 1'b0;
    endtask

    task automatic test_debounce;
        int n;
        logic [7:0] d;
        logic we;
        cpu_address = 16'h0300;
        btn = 4'b0001;
        wait_key(n);
        total++;
        if (n != D + 2) begin
            bad++; $display("FAIL press_latency: got %0d want %0d", n, D + 2);
        end
        cpu_read(16'h00FF, d);
        total++;
        if (d !== 8'h77) begin
            bad++; $display("FAIL press_up_code: got %h want 77", d);
        end
        cpu_write(16'h00FF, 8'h00, we);
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL clear_after_press: got %b want 0", key_valid);
        end
        step(12);
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL single_event_held: got %b want 0", key_valid);
        end
        btn = 4'b0000;
        step(15);
    endtask

    task automatic test_glitch;
        logic we;
        logic [7:0] d;
        cpu_write(16'h00FF, 8'h3C, we);
        btn = 4'b0010;
        step(5);
        btn = 4'b0000;
        step(15);
        cpu_read(16'h00FF, d);
        total++;
        if (d !== 8'h3C) begin
            bad++; $display("FAIL glitch_no_event: got %h want 3c", d);
        end
    endtask

    task automatic test_write_mask;
        logic we;
        logic [7:0] d;
        cpu_write(16'h08FF, 8'hA5, we);
        total++;
        if (we !== 1'b1) begin
            bad++; $display("FAIL mirror_write_we: got %b want 1", we);
        end
        cpu_write(16'h00FF, 8'h00, we);
        total++;
        if (we !== 1'b0) begin
            bad++; $display("FAIL io_write_masked: got %b want 0", we);
        end
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL write0_key_valid: got %b want 0", key_valid);
        end
        cpu_read(16'h00FF, d);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL write0_key: got %h want 00", d);
        end
        cpu_read(16'h08FF, d);
        total++;
        if (d !== 8'hA5) begin
            bad++; $display("FAIL ram_ff_untouched: got %h want a5", d);
        end
    endtask

    task automatic test_ram;
        logic we;
        logic [7:0] d;
        cpu_write(16'h0200, 8'h5A, we);
        total++;
        if (we !== 1'b1) begin
            bad++; $display("FAIL ram_write_we: got %b want 1", we);
        end
        cpu_read(16'h0200, d);
        total++;
        if (d !== 8'h5A) begin
            bad++; $display("FAIL ram_readback: got %h want 5a", d);
        end
    endtask

    task automatic test_back_to_back;
        btn = 4'b1001;
        step(D + 1);
        cpu_address = 16'h00FF;
        cpu_wdata   = 8'h11;
        cpu_we      = 1'b1;
        cpu_ce      = 1'b1;
        step(1);
        cpu_we = 1'b0;
        cpu_ce = 1'b0;
        total++;
        if (cpu_rdata !== 8'h77) begin
            bad++; $display("FAIL press_beats_write: got %h want 77", cpu_rdata);
        end
        total++;
        if (key_valid !== 1'b1) begin
            bad++; $display("FAIL press_beats_write_valid: got %b want 1", key_valid);
        end
        btn = 4'b0000;
        step(15);
    endtask

    task automatic test_reset_mid;
        logic we;
        logic [7:0] d;
        int n;
        cpu_write(16'h00FF, 8'h3C, we);
        step(1);
        btn = 4'b0100;
        step(5);
        reset = 1'b1;
        #1;
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset_key_valid: got %b want 0", key_valid);
        end
        total++;
        if (cpu_rdata !== ram_rdata) begin
            bad++; $display("FAIL async_reset_rdata: got %h want %h", cpu_rdata, ram_rdata);
        end
        total++;
        if (ram_write_en !== 1'b0) begin
            bad++; $display("FAIL async_reset_ram_we: got %b want 0", ram_write_en);
        end
        step(2);
        reset = 1'b0;
        wait_key(n);
        total++;
        if (n != D + 2) begin
            bad++; $display("FAIL held_after_reset_latency: got %0d want %0d", n, D + 2);
        end
        cpu_read(16'h00FF, d);
        total++;
        if (d !== 8'h61) begin
            bad++; $display("FAIL held_after_reset_code: got %h want 61", d);
        end
        btn = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_random;
        test_debounce;
        test_glitch;
        test_write_mask;
        test_ram;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
